// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
// Lane select, store replication and load extension are kept here so the FSM stays readable.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lsb[0];
            default: bad = (lsb != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lsb);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lsb;
            SZ_HALF: be = lsb[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {4{wd[7:0]}};
            SZ_HALF: r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                                input logic [1:0] lsb, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lsb, 3'b000});
        h = lsb[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
            SZ_HALF: r = {{16{h[15] & ~uns}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables and a registered read.
// Read returns the contents before a same-cycle write.
module mem_word_array #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-lane write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// Wait-state data-memory responder for the CPU load/store port: one request at a time,
// byte/half/word accesses with lane merging, load extension and misalignment flagging.
module data_mem_resp
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memen,
    input  logic        memwrite,
    input  logic [1:0]  memsize,
    input  logic        memunsigned,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        addr_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW+1:0]    adr_q, adr_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic             wr_q, wr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             addr_err_q, addr_err_d;

    logic [AW-1:0]    arr_addr_s;
    logic             arr_we_s;
    logic [3:0]       arr_be_s;
    logic [31:0]      arr_wdata_s;
    logic [31:0]      arr_rdata_s;
    logic             adr_unused_s;

    assign adr_unused_s = ^dataadr[31:AW+2];

    // Next-state logic for the request FSM and its latched request.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        addr_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (memen) begin
                    adr_d   = dataadr[AW+1:0];
                    size_d  = memsize;
                    uns_d   = memunsigned;
                    wr_d    = memwrite;
                    wdata_d = writedata;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d    = ST_RESP;
                        addr_err_d = is_misaligned(memsize, dataadr[1:0]);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!memen) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d    = ST_RESP;
                        addr_err_d = is_misaligned(size_q, adr_q[1:0]);
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and latched-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            adr_q      <= '0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= 32'h0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Only the idle state lets memen reach stall; no address path feeds it.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            ST_IDLE: stall = memen;
            ST_WAIT: stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // In IDLE the array reads the incoming address so zero-wait accesses have data in RESP.
    assign arr_addr_s  = (state_q == ST_IDLE) ? dataadr[AW+1:2] : adr_q[AW+1:2];
    assign arr_we_s    = (state_q == ST_RESP) && wr_q && !addr_err_q && !rst;
    assign arr_be_s    = lane_enables(size_q, adr_q[1:0]);
    assign arr_wdata_s = store_lanes(size_q, wdata_q);

    mem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (arr_we_s),
        .be   (arr_be_s),
        .addr (arr_addr_s),
        .wdata(arr_wdata_s),
        .rdata(arr_rdata_s)
    );

    // Load result: extended array word in a good RESP, zero otherwise.
    always_comb begin
        readdata = 32'h0;
        if ((state_q == ST_RESP) && !addr_err_q) begin
            readdata = load_extend(size_q, uns_q, adr_q[1:0], arr_rdata_s);
        end else begin
            readdata = 32'h0;
        end
    end

    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomized self-checking bench for data_mem_resp with 1, 3 and 0 wait states,
// against a byte-addressed little-endian memory model.
module tb_data_mem_resp;
    import mem_pkg::*;

    localparam int DEPTH = 64;
    localparam int NB    = 4 * DEPTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s       [3];
    logic        memen_s     [3];
    logic        memwrite_s  [3];
    logic [1:0]  memsize_s   [3];
    logic        memuns_s    [3];
    logic [31:0] dataadr_s   [3];
    logic [31:0] writedata_s [3];
    logic [31:0] readdata_s  [3];
    logic        stall_s     [3];
    logic        addr_err_s  [3];

    int n_checks = 0;
    int n_fail   = 0;
    int wc [3] = '{1, 3, 0};
    logic [7:0] mb [3][NB];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_resp #(
            .DEPTH_WORDS(DEPTH),
            .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
        ) u_dut (
            .clk        (clk),
            .rst        (rst_s[g]),
            .memen      (memen_s[g]),
            .memwrite   (memwrite_s[g]),
            .memsize    (memsize_s[g]),
            .memunsigned(memuns_s[g]),
            .dataadr    (dataadr_s[g]),
            .writedata  (writedata_s[g]),
            .readdata   (readdata_s[g]),
            .stall      (stall_s[g]),
            .addr_err   (addr_err_s[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == SZ_BYTE) ? 1 : ((sz == SZ_HALF) ? 2 : 4);
    endfunction

    function automatic logic [31:0] model_load(input int k, input logic [1:0] sz,
                                               input logic uns, input logic [31:0] adr);
        int nb;
        logic [31:0] v;
        logic [7:0] ba;
        nb = size_bytes(sz);
        v  = 32'h0;
        for (int i = 0; i < nb; i++) begin
            ba = adr[7:0] + 8'(i);
            v  = v | (32'(mb[k][ba]) << (8 * i));
        end
        if (nb < 4 && !uns && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic access(input int k, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] adr, input logic [31:0] wd, output logic [31:0] rd);
        int   nb;
        int   stalls;
        bit   done;
        logic early;
        logic err;
        logic mis;
        logic [7:0] ba;
        nb     = size_bytes(sz);
        mis    = (adr % nb) != 0;
        stalls = 0;
        done   = 1'b0;
        early  = 1'b0;
        err    = 1'b0;
        rd     = 32'h0;
        @(negedge clk);
        memen_s[k] = 1'b1; memwrite_s[k] = wr; memsize_s[k] = sz;
        memuns_s[k] = uns; dataadr_s[k] = adr; writedata_s[k] = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall_s[k]) begin
                stalls++;
                if (addr_err_s[k]) early = 1'b1;
                @(negedge clk);
            end else begin
                rd   = readdata_s[k];
                err  = addr_err_s[k];
                done = 1'b1;
            end
        end
        memen_s[k] = 1'b0;
        check("resp_seen", 32'(done), 32'd1);
        check("stall_cycles", 32'(stalls), 32'(wc[k] + 1));
        check("addr_err_early", 32'(early), 32'd0);
        check("addr_err", 32'(err), 32'(mis));
        if (mis) check("rd_misaligned", rd, 32'h0);
        else if (!wr) check("load", rd, model_load(k, sz, uns, adr));
        if (wr && !mis) begin
            for (int i = 0; i < nb; i++) begin
                ba = adr[7:0] + 8'(i);
                mb[k][ba] = 8'(wd >> (8 * i));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got time %0t required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] adr;
        logic [1:0]  sz;
        int          k;
        for (int i = 0; i < 3; i++) begin
            rst_s[i] = 1'b1; memen_s[i] = 1'b0; memwrite_s[i] = 1'b0; memsize_s[i] = 2'b00;
            memuns_s[i] = 1'b0; dataadr_s[i] = 32'h0; writedata_s[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_stall", 32'(stall_s[i]), 32'd0);
            check("reset_readdata", readdata_s[i], 32'h0);
            check("reset_addr_err", 32'(addr_err_s[i]), 32'd0);
        end

        // Give every word a known value so later loads are fully predictable.
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < DEPTH; w++) access(i, 1'b1, SZ_WORD, 1'b0, 32'(w * 4), $urandom, rd);

        access(0, 1'b1, SZ_WORD, 1'b0, 32'd84, 32'd7, rd);
        access(0, 1'b0, SZ_WORD, 1'b0, 32'd84, 32'h0, rd);
        check("load_84", rd, 32'h0000_0007);
        access(0, 1'b1, SZ_WORD, 1'b0, 32'd80, 32'h1122_3344, rd);
        access(0, 1'b1, SZ_BYTE, 1'b0, 32'd82, 32'h0000_00AA, rd);
        access(0, 1'b0, SZ_WORD, 1'b0, 32'd80, 32'h0, rd);
        check("byte_merge", rd, 32'h11AA_3344);
        access(0, 1'b1, SZ_HALF, 1'b0, 32'd86, 32'h0000_8001, rd);
        access(0, 1'b0, SZ_HALF, 1'b0, 32'd86, 32'h0, rd);
        check("half_signed", rd, 32'hFFFF_8001);
        access(0, 1'b0, SZ_HALF, 1'b1, 32'd86, 32'h0, rd);
        check("half_unsigned", rd, 32'h0000_8001);
        access(0, 1'b1, SZ_WORD, 1'b0, 32'd81, 32'hCAFE_F00D, rd);
        access(0, 1'b0, SZ_WORD, 1'b0, 32'd80, 32'h0, rd);
        check("misaligned_no_write", rd, 32'h11AA_3344);

        // Reset during the second wait state of a store on the 3-wait instance.
        @(negedge clk);
        memen_s[1] = 1'b1; memwrite_s[1] = 1'b1; memsize_s[1] = SZ_WORD;
        memuns_s[1] = 1'b0; dataadr_s[1] = 32'd84; writedata_s[1] = 32'd5;
        @(negedge clk);
        @(negedge clk);
        rst_s[1] = 1'b1;
        @(negedge clk);
        rst_s[1] = 1'b0; memen_s[1] = 1'b0;
        #1;
        check("rst_stall", 32'(stall_s[1]), 32'd0);
        check("rst_addr_err", 32'(addr_err_s[1]), 32'd0);
        check("rst_readdata", readdata_s[1], 32'h0);
        access(1, 1'b0, SZ_WORD, 1'b0, 32'd84, 32'h0, rd);

        // Request withdrawn mid-wait: no store may land.
        @(negedge clk);
        memen_s[1] = 1'b1; memwrite_s[1] = 1'b1; memsize_s[1] = SZ_WORD;
        dataadr_s[1] = 32'd88; writedata_s[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        memen_s[1] = 1'b0;
        @(negedge clk);
        #1;
        check("abort_stall", 32'(stall_s[1]), 32'd0);
        access(1, 1'b0, SZ_WORD, 1'b0, 32'd88, 32'h0, rd);

        access(2, 1'b1, SZ_WORD, 1'b0, 32'(4 * DEPTH + 4), 32'h5A5A_1234, rd);
        access(2, 1'b0, SZ_WORD, 1'b0, 32'd4, 32'h0, rd);
        check("alias_wrap", rd, 32'h5A5A_1234);

        for (int n = 0; n < 300; n++) begin
            k   = $urandom_range(0, 2);
            sz  = 2'($urandom_range(0, 3));
            adr = $urandom;
            if ($urandom_range(0, 3) != 0) adr = adr & ~32'(size_bytes(sz) - 1);
            access(k, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), adr, $urandom, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
